// File: rtl/fpu_pkg.sv
// +--------------------------------------------------------------------------+
// | fpu_pkg: shared FPU field widths, special-value constants, FSM states.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

  localparam int C_INT_SIZE      = 32;
  localparam int C_PRECISION     = 32;
  localparam int C_EXPONENT_SIZE = 8;
  localparam int C_MANTISSA_SIZE = 23;
  localparam int C_EXP_BIAS      = 2**(C_EXPONENT_SIZE-1) - 1;

  localparam logic [C_EXPONENT_SIZE-1:0] C_EXP_ONES = '1;
  localparam logic [C_EXPONENT_SIZE-1:0] C_EXP_ZERO = '0;

  localparam logic [C_INT_SIZE-1:0] C_SAT_POS = {1'b0, {(C_INT_SIZE-1){1'b1}}};
  localparam logic [C_INT_SIZE-1:0] C_SAT_NEG = {1'b1, {(C_INT_SIZE-1){1'b0}}};

  // Working register: integer part (one spare bit) above mantissa_size fraction bits
  localparam int C_WORK_W = C_INT_SIZE + C_MANTISSA_SIZE + 1;
  localparam int C_CNT_W  = $clog2(C_INT_SIZE);

  typedef logic signed [C_EXPONENT_SIZE:0] fpu_exp_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLASSIFY = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_ROUND    = 2'd3
  } fpu_state_t;

endpackage

`default_nettype wire

// File: rtl/fp_to_int_if.sv
// +--------------------------------------------------------------------------+
// | fp_to_int_if: request/result bundle of the float-to-integer converter.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface fp_to_int_if;
  import fpu_pkg::*;

  logic                   start;
  logic [C_PRECISION-1:0] fp;
  logic                   busy;
  logic                   done;
  logic [C_INT_SIZE-1:0]  int_out;
  logic                   invalid;
  logic                   inexact;

  modport master (output start, fp, input busy, done, int_out, invalid, inexact);
  modport slave  (input start, fp, output busy, done, int_out, invalid, inexact);
endinterface

`default_nettype wire

// File: rtl/fp_classify.sv
// +--------------------------------------------------------------------------+
// | fp_classify: combinational field decode (NaN/inf/zero/denormal, e).      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp_classify
  import fpu_pkg::*;
(
  input  logic [C_PRECISION-1:0]     i_fp,
  output logic                       o_sign,
  output logic                       o_is_nan,
  output logic                       o_is_inf,
  output logic                       o_is_zero,
  output logic                       o_is_denorm,
  output fpu_exp_t                   o_exp_unb,
  output logic [C_MANTISSA_SIZE-1:0] o_mantissa
);

  logic [C_EXPONENT_SIZE-1:0] w_exp;
  logic                       w_man_nz;

  assign w_exp       = i_fp[C_PRECISION-2 -: C_EXPONENT_SIZE];
  assign o_mantissa  = i_fp[C_MANTISSA_SIZE-1:0];
  assign o_sign      = i_fp[C_PRECISION-1];
  assign w_man_nz    = |o_mantissa;

  assign o_is_nan    = (w_exp == C_EXP_ONES) &&  w_man_nz;
  assign o_is_inf    = (w_exp == C_EXP_ONES) && !w_man_nz;
  assign o_is_zero   = (w_exp == C_EXP_ZERO) && !w_man_nz;
  assign o_is_denorm = (w_exp == C_EXP_ZERO) &&  w_man_nz;
  assign o_exp_unb   = fpu_exp_t'({1'b0, w_exp}) - fpu_exp_t'(C_EXP_BIAS);

endmodule

`default_nettype wire

// File: rtl/fp_to_int.sv
// +--------------------------------------------------------------------------+
// | fp_to_int: multi-cycle float to signed integer, one shift per cycle.     |
// | FP_TO_INT_ROUND_EN selects round-to-nearest-even, else truncation.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp_to_int
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  fp_to_int_if.slave  bus
);

  fpu_state_t                 r_state, w_state_next;
  logic [C_PRECISION-1:0]     r_fp;
  logic [C_WORK_W-1:0]        r_work;
  logic                       r_sticky;
  logic [C_CNT_W-1:0]         r_cnt;
  logic                       r_left;
  logic [C_INT_SIZE-1:0]      r_int;
  logic                       r_invalid, r_inexact, r_done;

  logic                       w_sign, w_is_nan, w_is_inf, w_is_zero, w_is_denorm;
  fpu_exp_t                   w_e;
  logic [C_MANTISSA_SIZE-1:0] w_man;
  logic [C_INT_SIZE-1:0]      w_sat, w_rounded, w_res_int;
  logic [C_INT_SIZE:0]        w_mag, w_mag_rnd;
  logic                       w_guard, w_sticky, w_ovf;
  logic                       w_load, w_res_inv, w_res_inx, w_go_normal;
  logic [C_CNT_W-1:0]         w_shift_cnt;

  fp_classify u_classify (
    .i_fp        (r_fp),
    .o_sign      (w_sign),
    .o_is_nan    (w_is_nan),
    .o_is_inf    (w_is_inf),
    .o_is_zero   (w_is_zero),
    .o_is_denorm (w_is_denorm),
    .o_exp_unb   (w_e),
    .o_mantissa  (w_man)
  );

  assign w_sat       = w_sign ? C_SAT_NEG : C_SAT_POS;
  // Only e == -1 reaches SHIFT with a negative exponent
  assign w_shift_cnt = w_e[C_EXPONENT_SIZE] ? C_CNT_W'(1) : w_e[C_CNT_W-1:0];

  assign w_mag    = r_work[C_WORK_W-1:C_MANTISSA_SIZE];
  assign w_guard  = r_work[C_MANTISSA_SIZE-1];
  assign w_sticky = r_sticky | (|r_work[C_MANTISSA_SIZE-2:0]);

`ifdef FP_TO_INT_ROUND_EN
  assign w_mag_rnd = w_mag + {{C_INT_SIZE{1'b0}}, w_guard & (w_sticky | w_mag[0])};
`else
  assign w_mag_rnd = w_mag;
`endif

  // Negative results may reach magnitude 2^(int_size-1), positive ones may not
  assign w_ovf     = w_sign ? (w_mag_rnd > {1'b0, C_SAT_NEG}) : (w_mag_rnd > {1'b0, C_SAT_POS});
  assign w_rounded = w_sign ? (C_INT_SIZE'(0) - w_mag_rnd[C_INT_SIZE-1:0]) : w_mag_rnd[C_INT_SIZE-1:0];

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_res_int    = '0;
    w_res_inv    = 1'b0;
    w_res_inx    = 1'b0;
    w_go_normal  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_next = ST_CLASSIFY;
      end
      ST_CLASSIFY: begin
        w_load       = 1'b1;
        w_state_next = ST_IDLE;
        if (w_is_nan) begin
          w_res_int = C_SAT_POS;
          w_res_inv = 1'b1;
        end else if (w_is_inf) begin
          w_res_int = w_sat;
          w_res_inv = 1'b1;
        end else if (w_e >= fpu_exp_t'(C_INT_SIZE-1)) begin
          w_res_int = w_sat;
          w_res_inv = !(w_sign && (w_e == fpu_exp_t'(C_INT_SIZE-1)) && (w_man == '0));
        end else if (w_is_zero || w_is_denorm || (w_e <= fpu_exp_t'(-2))) begin
          w_res_inx = !w_is_zero;
        end else begin
          w_load       = 1'b0;
          w_go_normal  = 1'b1;
          w_state_next = (w_e == '0) ? ST_ROUND : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == C_CNT_W'(1)) w_state_next = ST_ROUND;
      end
      ST_ROUND: begin
        w_load       = 1'b1;
        w_state_next = ST_IDLE;
        w_res_int    = w_ovf ? w_sat : w_rounded;
        w_res_inv    = w_ovf;
        w_res_inx    = w_guard | w_sticky;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fp      <= '0;
      r_work    <= '0;
      r_sticky  <= 1'b0;
      r_cnt     <= '0;
      r_left    <= 1'b0;
      r_int     <= '0;
      r_invalid <= 1'b0;
      r_inexact <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) begin
        r_int     <= w_res_int;
        r_invalid <= w_res_inv;
        r_inexact <= w_res_inx;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.start) r_fp <= bus.fp;
        end
        ST_CLASSIFY: begin
          if (w_go_normal) begin
            r_work   <= C_WORK_W'({1'b1, w_man});
            r_sticky <= 1'b0;
            r_cnt    <= w_shift_cnt;
            r_left   <= !w_e[C_EXPONENT_SIZE];
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt - C_CNT_W'(1);
          if (r_left) begin
            r_work <= r_work << 1;
          end else begin
            r_work   <= r_work >> 1;
            r_sticky <= r_sticky | r_work[0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (r_state != ST_IDLE);
  assign bus.done    = r_done;
  assign bus.int_out = r_int;
  assign bus.invalid = r_invalid;
  assign bus.inexact = r_inexact;

endmodule

`default_nettype wire

// File: tb/tb_fp_to_int.sv
// +--------------------------------------------------------------------------+
// | tb_fp_to_int: directed vectors for fp_to_int (both rounding builds).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fp_to_int;

`ifdef FP_TO_INT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  fp_to_int_if bus();

  fp_to_int dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen,
  // so consecutive calls exercise start-in-done-cycle acceptance.
  task automatic convert(input string tag, input logic [31:0] val, input logic [31:0] e_int,
                         input logic e_inv, input logic e_inx, input int e_lat, input bit poke);
    int n;
    bit seen;
    bus.fp    = val;
    bus.start = 1'b1;
    @(negedge clk);
    n = 1;
    check({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
    bus.start = poke;
    if (poke) bus.fp = 32'h4F000000;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    bus.start = 1'b0;
    check({tag, " done"},    {31'b0, bus.done},    32'd1);
    check({tag, " latency"}, n,                    e_lat);
    check({tag, " int"},     bus.int_out,          e_int);
    check({tag, " invalid"}, {31'b0, bus.invalid}, {31'b0, e_inv});
    check({tag, " inexact"}, {31'b0, bus.inexact}, {31'b0, e_inx});
    check({tag, " busy@done"}, {31'b0, bus.busy},  32'd0);
    if (poke) begin
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        seen |= bus.done;
      end
      check({tag, " extra done"}, {31'b0, seen}, 32'd0);
      check({tag, " int held"},   bus.int_out,   e_int);
    end
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.fp    = '0;
    repeat (3) @(negedge clk);
    check("rst int",     bus.int_out,          32'd0);
    check("rst invalid", {31'b0, bus.invalid}, 32'd0);
    check("rst inexact", {31'b0, bus.inexact}, 32'd0);
    check("rst done",    {31'b0, bus.done},    32'd0);
    check("rst busy",    {31'b0, bus.busy},    32'd0);
    reset = 1'b1;
    @(negedge clk);

    convert("1.5",     32'h3FC00000, RND ? 32'd2 : 32'd1,               1'b0, 1'b1, 3, 1'b0);
    convert("-123.45", 32'hC2F6E666, 32'hFFFFFF85,                      1'b0, 1'b1, 9, 1'b0);
    convert("2^31",    32'h4F000000, 32'h7FFFFFFF,                      1'b1, 1'b0, 2, 1'b0);
    convert("-2^31",   32'hCF000000, 32'h80000000,                      1'b0, 1'b0, 2, 1'b0);
    convert("nan",     32'h7FC00000, 32'h7FFFFFFF,                      1'b1, 1'b0, 2, 1'b0);
    convert("denorm",  32'h00000001, 32'd0,                             1'b0, 1'b1, 2, 1'b0);
    convert("zero",    32'h00000000, 32'd0,                             1'b0, 1'b0, 2, 1'b0);
    convert("0.25",    32'h3E800000, 32'd0,                             1'b0, 1'b1, 2, 1'b0);
    convert("0.5",     32'h3F000000, 32'd0,                             1'b0, 1'b1, 4, 1'b0);
    convert("0.75",    32'h3F400000, RND ? 32'd1 : 32'd0,               1'b0, 1'b1, 4, 1'b1);
    convert("2.5",     32'h40200000, 32'd2,                             1'b0, 1'b1, 4, 1'b0);
    convert("+inf",    32'h7F800000, 32'h7FFFFFFF,                      1'b1, 1'b0, 2, 1'b0);
    convert("-inf",    32'hFF800000, 32'h80000000,                      1'b1, 1'b0, 2, 1'b0);
    convert("-0.75",   32'hBF400000, RND ? 32'hFFFFFFFF : 32'd0,        1'b0, 1'b1, 4, 1'b0);
    convert("123.0",   32'h42F60000, 32'h0000007B,                      1'b0, 1'b0, 9, 1'b0);

    // Abort a long conversion mid-shift
    bus.fp    = 32'h4E800000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort busy before", {31'b0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort int",     bus.int_out,          32'd0);
    check("abort invalid", {31'b0, bus.invalid}, 32'd0);
    check("abort inexact", {31'b0, bus.inexact}, 32'd0);
    check("abort done",    {31'b0, bus.done},    32'd0);
    check("abort busy",    {31'b0, bus.busy},    32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.done;
    end
    check("abort no done", {31'b0, seen}, 32'd0);

    convert("2^30",    32'h4E800000, 32'h40000000,                      1'b0, 1'b0, 33, 1'b0);
    convert("max<2^31", 32'h4EFFFFFF, 32'h7FFFFF80,                     1'b0, 1'b0, 33, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_to_int.md
# fp_to_int

Multi-cycle converter from IEEE-754-style floating point to two's-complement signed integer. It is the return path for the FPU's integer-to-float converter and uses the same field parameters and the same sign/exponent/mantissa packing. The block accepts one operand per start pulse and shifts the significand one bit per cycle. It returns the integer, `invalid`/`inexact` flags and a one-cycle `done` pulse.

## Interface
- `int_size`, 32, width of the integer result
- `precision`, 32, width of the float operand
- `exponent_size`, 8, exponent field width
- `mantissa_size`, 23, stored mantissa width (`precision = 1 + exponent_size + mantissa_size`)
- `exp_bias`, `2^(exponent_size-1)-1`, exponent bias
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `fp`  in  precision  operand {sign, exp, mantissa}; sampled with `start`
- `busy`  out  1  high in every state other than IDLE
- `done`  out  1  one-cycle pulse; `int`/flags valid from this cycle until the next `done`
- `int`  out  int_size  signed result
- `invalid`  out  1  NaN, infinity or out-of-range operand; result saturated
- `inexact`  out  1  nonzero fraction discarded or rounded

## Operation
- States: IDLE, CLASSIFY, SHIFT, ROUND.
- IDLE, `start`=1: register `fp`, go to CLASSIFY. `start` while `busy` is ignored, not queued.
- CLASSIFY: unbiased exponent `e = exp - exp_bias` (signed, exponent_size+1 bits).
  - exp all-ones, mantissa != 0 (NaN): result `2^(int_size-1)-1`, `invalid`=1.
  - exp all-ones, mantissa == 0 (±inf): saturate by sign, `invalid`=1.
  - `e >= int_size-1`: saturate by sign, `invalid`=1. Exception: sign=1, `e == int_size-1`, mantissa == 0 gives `-2^(int_size-1)` with no flag.
  - exp == 0 (zero or denormal), or `e <= -2`: result 0; `inexact` = (value != 0). With rounding, |x| < 0.5 still yields 0.
  - Every case above ends the operation directly: outputs are loaded and `done` is set at the CLASSIFY exit edge. There is no SHIFT or ROUND.
  - Otherwise: load working register R (int_size+mantissa_size+1 bits) = `{0…, 1, mantissa}`, with mantissa_size fractional bits and sticky bit S=0. Set shift counter to |e|. Go to SHIFT, or directly to ROUND if e == 0.
- SHIFT: one bit per cycle. Left for e > 0. Right for e = -1, OR-ing the shifted-out bit into S. Counter decrements; leave for ROUND when it reaches 0.
- ROUND:
  - Integer magnitude = R integer part. Guard = top fraction bit. Sticky = S | remaining fraction bits.
  - Apply rounding (see Configuration).
  - Negate if sign=1.
  - If the rounded magnitude exceeds the signed range, saturate and set `invalid`.
  - `inexact` = guard | sticky.
  - Load `int`/flags, pulse `done`, go to IDLE.

## Timing
- Reset values: `int`=0, `invalid`=0, `inexact`=0, `done`=0, `busy`=0, state IDLE, R=0.
- `start` sampled at edge k. `done` is high during cycle k+2 for special/zero cases, and during cycle k+3+|e| for normal cases. Maximum latency is int_size+1 cycles.
- `busy` is high from k+1 until the edge that raises `done`. `done` and `busy` are never high together.
- `start` in the same cycle as `done` is accepted, because the state is already IDLE. Back-to-back throughput is latency+0.
- Reset asserted mid-operation: immediate return to IDLE, all outputs cleared, no `done` for the aborted operand.
- `int`/flags hold their value between operations. They change only at the edge that raises `done`.

## Configuration
- `FP_TO_INT_ROUND_EN` defined: round-to-nearest, ties-to-even. Increment the magnitude when guard & (sticky | lsb).
- Undefined: truncate toward zero, no increment logic.
- ROUND state, latency and `inexact` behaviour are identical in both builds.

## Structure
- Shared `fpu_pkg` holds:
  - field-width/bias constants;
  - exponent all-ones/zero constants;
  - saturation values;
  - state enum typedef, shared with the int-to-float converter's future FSM.
- Sub-module `fp_classify`, combinational: decodes NaN/inf/zero/denormal and unbiased `e` from the fields. It is reusable by other FPU blocks.

## Test plan
- `fp`=0x3FC00000 (1.5): with the macro defined, `int`=2, `inexact`=1, `done` 3 cycles after start. Undefined: `int`=1.
- `fp`=0xC2F6E666 (-123.45): `int`=0xFFFFFF85, `inexact`=1, `invalid`=0, `done` 9 cycles after start.
- `fp`=0x4F000000 (2^31): `int`=0x7FFFFFFF, `invalid`=1. `fp`=0xCF000000: `int`=0x80000000, `invalid`=0. Both `done` at 2 cycles.
- `fp`=0x7FC00000 (NaN): `int`=0x7FFFFFFF, `invalid`=1. `fp`=0x00000001 (denormal): `int`=0, `inexact`=1.
- `fp`=0x3F000000 (0.5) with rounding: `int`=0. `fp`=0x3F400000 (0.75): `int`=1, `inexact`=1. A second `start` pulsed while `busy` produces no extra `done`.
- `fp`=0x4E800000 (2^30): drop `reset` at cycle 10 mid-SHIFT. All outputs read 0, no `done` appears, and the next operand converts correctly.
